// File: rtl/mips_defs_pkg.sv
// Core-wide MIPS constants shared by fetch, CP0 and the memory stage.
package mips_defs;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned EXCCODE_W = 5;
  localparam int unsigned IM_WORDS  = 2048;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] EXC_VEC  = 32'h0000_4180;
  localparam logic [XLEN-1:0] IM_BASE  = 32'h0000_3000;
  localparam logic [XLEN-1:0] IM_LAST  = IM_BASE + XLEN'(4 * IM_WORDS) - 32'd4;

  localparam logic [EXCCODE_W-1:0] EXC_ADEL = 5'd4;

  // Payload handed to the F/D pipeline register.
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      instr;
    logic                 valid;
    logic                 exc;
    logic [EXCCODE_W-1:0] exccode;
  } f_bundle_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Instruction-address check: flags misaligned or out-of-memory fetch addresses.
module fetch_addr_check
  import mips_defs::*;
(
  input  logic [XLEN-1:0] addr_i,
  output logic            fault_c_o
);

  logic misaligned_c;
  logic out_of_range_c;

  assign misaligned_c   = (addr_i[1:0] != 2'b00);
  assign out_of_range_c = (addr_i < IM_BASE) || (addr_i > IM_LAST);
  assign fault_c_o      = misaligned_c | out_of_range_c;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC unit: next-PC selection, synchronous-BRAM address drive and
// F-stage output gating with AdEL detection.
module fetch_pc_unit
  import mips_defs::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  input  logic                 exc_req,
  input  logic                 eret_req,
  input  logic [XLEN-1:0]      epc,
  output logic [XLEN-1:0]      im_addr,
  input  logic [XLEN-1:0]      im_instr,
  output logic [XLEN-1:0]      f_pc,
  output logic [XLEN-1:0]      f_instr,
  output logic                 f_valid,
  output logic                 f_exc,
  output logic [EXCCODE_W-1:0] f_exccode
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            adel_q, adel_d;
  logic            valid_q, valid_d;
  f_bundle_t       f_bus_c;

  // Next-PC priority mux; the cycle right after reset re-presents RESET_PC so
  // its word is fetched with valid set.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (exc_req) begin
      pc_d = EXC_VEC;
    end else if (eret_req) begin
      pc_d = epc;
    end else if (stall || !valid_q) begin
      pc_d = pc_q;
    end else if (redirect_valid) begin
      pc_d = redirect_pc;
    end
  end

  assign valid_d = 1'b1;

  fetch_addr_check u_addr_check (
    .addr_i    (pc_d),
    .fault_c_o (adel_d)
  );

  assign im_addr = reset_n ? pc_d : RESET_PC;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      adel_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      adel_q  <= adel_d;
      valid_q <= valid_d;
    end
  end

  // Faulting or invalid fetches present a nop.
  always_comb begin
    f_bus_c         = '0;
    f_bus_c.pc      = pc_q;
    f_bus_c.valid   = valid_q;
    f_bus_c.exc     = valid_q & adel_q;
    f_bus_c.exccode = (valid_q & adel_q) ? EXC_ADEL : '0;
    f_bus_c.instr   = (valid_q & ~adel_q) ? im_instr : '0;
  end

  assign f_pc      = f_bus_c.pc;
  assign f_instr   = f_bus_c.instr;
  assign f_valid   = f_bus_c.valid;
  assign f_exc     = f_bus_c.exc;
  assign f_exccode = f_bus_c.exccode;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit with a synchronous-read BRAM model and
// a scoreboard of expected F-stage outputs.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_valid;
  logic        f_exc;
  logic [4:0]  f_exccode;

  fetch_pc_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_req        (exc_req),
    .eret_req       (eret_req),
    .epc            (epc),
    .im_addr        (im_addr),
    .im_instr       (im_instr),
    .f_pc           (f_pc),
    .f_instr        (f_instr),
    .f_valid        (f_valid),
    .f_exc          (f_exc),
    .f_exccode      (f_exccode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h0000_3000;
    if (a[1:0] == 2'b00 && a >= 32'h0000_3000 && a <= 32'h0000_4FFC)
      return mem[off[12:2]];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_4FFC);
  endfunction

  always @(posedge clk) im_instr <= word_at(im_addr);

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_adel;
  logic [70:0] sb [$];
  logic [70:0] e;
  logic [70:0] obs;

  // Drives one cycle of inputs, predicts the post-edge outputs, advances past the edge.
  task automatic drive_cycle(input logic st, input logic rv, input logic [31:0] rpc,
                             input logic ex, input logic er, input logic [31:0] ep);
    logic [31:0] npc;
    logic [31:0] ins;
    stall = st; redirect_valid = rv; redirect_pc = rpc;
    exc_req = ex; eret_req = er; epc = ep;
    if (ex)                 npc = 32'h0000_4180;
    else if (er)            npc = ep;
    else if (st || !m_valid) npc = m_pc;
    else if (rv)            npc = rpc;
    else                    npc = m_pc + 32'd4;
    m_pc    = npc;
    m_adel  = addr_fault(npc);
    m_valid = 1'b1;
    ins     = m_adel ? 32'h0 : word_at(npc);
    sb.push_back({m_pc, ins, 1'b1, m_adel, (m_adel ? 5'd4 : 5'd0)});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
    m_pc = 32'h0000_3000; m_valid = 1'b0; m_adel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({f_pc, f_instr, f_valid, f_exc, f_exccode} !== {32'h3000, 32'h0, 1'b0, 1'b0, 5'd0}) begin
      n_errors++;
      $display("FAIL reset_outputs got pc=%h instr=%h v=%b exc=%b code=%0d", f_pc, f_instr, f_valid, f_exc, f_exccode);
    end
    n_checks++;
    if (im_addr !== 32'h0000_3000) begin
      n_errors++;
      $display("FAIL reset_im_addr got %h exp 00003000", im_addr);
    end
  endtask

  task automatic test_startup();
    reset_n = 1'b1;
    idle();
    e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
    n_checks++;
    if (obs !== e) begin n_errors++; $display("FAIL startup_c1 got %h exp %h", obs, e); end
    n_checks++;
    if ({f_pc, f_instr, f_valid} !== {32'h3000, 32'h2401_0001, 1'b1}) begin
      n_errors++;
      $display("FAIL startup_c1_const got pc=%h instr=%h v=%b exp 3000/24010001/1", f_pc, f_instr, f_valid);
    end
    idle();
    e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
    n_checks++;
    if (obs !== e || f_pc !== 32'h3004 || f_instr !== 32'h2402_0002) begin
      n_errors++;
      $display("FAIL startup_c2 got pc=%h instr=%h exp pc=00003004 instr=24020002", f_pc, f_instr);
    end
  endtask

  task automatic test_stall();
    idle();
    e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
    n_checks++;
    if (obs !== e || f_pc !== 32'h3008) begin n_errors++; $display("FAIL stall_pre got %h exp %h", obs, e); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
      n_checks++;
      if (obs !== e || f_pc !== 32'h3008 || f_instr !== 32'hA000_0002) begin
        n_errors++;
        $display("FAIL stall_hold cyc %0d got pc=%h instr=%h exp 00003008/a0000002", i, f_pc, f_instr);
      end
      n_checks++;
      if (im_addr !== 32'h3008) begin
        n_errors++;
        $display("FAIL stall_im_addr cyc %0d got %h exp 00003008", i, im_addr);
      end
    end
    idle();
    e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
    n_checks++;
    if (obs !== e || f_pc !== 32'h300C) begin n_errors++; $display("FAIL stall_resume got pc=%h exp 0000300c", f_pc); end
  endtask

  task automatic test_redirect();
    drive_cycle(1'b1, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0);
    e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
    n_checks++;
    if (obs !== e || f_pc !== 32'h300C) begin n_errors++; $display("FAIL redirect_stalled got pc=%h exp 0000300c", f_pc); end
    drive_cycle(1'b0, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0);
    e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
    n_checks++;
    if (obs !== e || f_pc !== 32'h3100 || f_instr !== 32'hA000_0040) begin
      n_errors++;
      $display("FAIL redirect_taken got pc=%h instr=%h exp 00003100/a0000040", f_pc, f_instr);
    end
  endtask

  task automatic test_exc_eret();
    drive_cycle(1'b1, 1'b1, 32'h3200, 1'b1, 1'b0, 32'h0);
    e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
    n_checks++;
    if (obs !== e || f_pc !== 32'h4180 || f_exc !== 1'b0 || f_instr !== 32'hA000_0460) begin
      n_errors++;
      $display("FAIL exc_entry got pc=%h exc=%b instr=%h exp 00004180/0/a0000460", f_pc, f_exc, f_instr);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3020);
    e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
    n_checks++;
    if (obs !== e || f_pc !== 32'h3020 || f_instr !== 32'hA000_0008) begin
      n_errors++;
      $display("FAIL eret_return got pc=%h instr=%h exp 00003020/a0000008", f_pc, f_instr);
    end
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3020);
    e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
    n_checks++;
    if (obs !== e || f_pc !== 32'h4180) begin n_errors++; $display("FAIL exc_over_eret got pc=%h exp 00004180", f_pc); end
  endtask

  task automatic test_adel();
    logic [31:0] tgt [6];
    logic        rv  [6];
    logic        flt [6];
    tgt = '{32'h3102, 32'h5000, 32'h4FFC, 32'h0, 32'h2FFC, 32'hFFFF_FFFC};
    rv  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    flt = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, rv[i], tgt[i], 1'b0, 1'b0, 32'h0);
      e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
      n_checks++;
      if (obs !== e) begin n_errors++; $display("FAIL adel_sb step %0d got %h exp %h", i, obs, e); end
      n_checks++;
      if (flt[i] && {f_exc, f_exccode, f_instr, f_valid} !== {1'b1, 5'd4, 32'h0, 1'b1}) begin
        n_errors++;
        $display("FAIL adel_flag step %0d got exc=%b code=%0d instr=%h exp 1/4/0", i, f_exc, f_exccode, f_instr);
      end else if (!flt[i] && {f_exc, f_exccode, f_instr} !== {1'b0, 5'd0, 32'hA000_07FF}) begin
        n_errors++;
        $display("FAIL adel_last_word got exc=%b instr=%h exp 0/a00007ff", f_exc, f_instr);
      end
    end
    idle();
    e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
    n_checks++;
    if (obs !== e || f_pc !== 32'h0 || f_exc !== 1'b1) begin
      n_errors++;
      $display("FAIL adel_wrap got pc=%h exc=%b exp 00000000/1", f_pc, f_exc);
    end
  endtask

  task automatic test_back_to_back();
    logic        st, rv, ex, er;
    logic [31:0] rpc, ep;
    for (int i = 0; i < 80; i++) begin
      st  = ($urandom % 4) == 0;
      rv  = ($urandom % 3) == 0;
      ex  = ($urandom % 16) == 0;
      er  = ($urandom % 12) == 0;
      rpc = 32'h3000 + (32'($urandom_range(0, 2047)) << 2) + (($urandom % 8 == 0) ? 32'd2 : 32'd0);
      ep  = 32'h3000 + (32'($urandom_range(0, 2100)) << 2);
      drive_cycle(st, rv, rpc, ex, er, ep);
      e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
      n_checks++;
      if (obs !== e) begin n_errors++; $display("FAIL b2b cyc %0d got %h exp %h", i, obs, e); end
    end
  endtask

  task automatic test_reset_midrun();
    drive_cycle(1'b0, 1'b1, 32'h3040, 1'b0, 1'b0, 32'h0);
    e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
    n_checks++;
    if (obs !== e || f_pc !== 32'h3040) begin n_errors++; $display("FAIL midrun_pre got pc=%h exp 00003040", f_pc); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({f_pc, f_valid, f_instr, im_addr} !== {32'h3000, 1'b0, 32'h0, 32'h3000}) begin
      n_errors++;
      $display("FAIL midrun_async got pc=%h v=%b instr=%h im_addr=%h exp 3000/0/0/3000", f_pc, f_valid, f_instr, im_addr);
    end
    m_pc = 32'h3000; m_valid = 1'b0; m_adel = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle();
    e = sb.pop_front(); obs = {f_pc, f_instr, f_valid, f_exc, f_exccode};
    n_checks++;
    if (obs !== e || f_pc !== 32'h3000 || f_instr !== 32'h2401_0001) begin
      n_errors++;
      $display("FAIL midrun_restart got pc=%h instr=%h exp 00003000/24010001", f_pc, f_instr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h2401_0001;
    mem[1] = 32'h2402_0002;
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_exc_eret();
    test_adel();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
